// File: rtl/cpu_multicycle.sv
// Multi-cycle Simple RISC core: FETCH/DECODE/EXEC/MEM/WB sequencing over one req/ready memory port.
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module cpu_multicycle #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int RESULT_REG = 7
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] Result,
    output logic              halted,
    output logic [31:0]       instr_count
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b0101;
    localparam logic [3:0] OP_LW   = 4'b0110;
    localparam logic [3:0] OP_SW   = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [ADDR_W-1:0] PC_ONE  = 1;
    localparam logic [2:0]        RES_IDX = RESULT_REG[2:0];

    logic [2:0]        state, state_next;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] a, b, alu_out, alu_res, mdr;
    logic [DATA_W-1:0] regs [8];

    logic [3:0]        op;
    logic              r_type, alu_op, is_lw, is_sw, is_beq, is_halt;
    logic [2:0]        rs1_sel, rs2_sel, rd_sel;
    logic [DATA_W-1:0] imm_d;
    logic [ADDR_W-1:0] imm_a;

    assign op      = ir[15:12];
    assign r_type  = (op <= OP_XOR);
    assign alu_op  = r_type || (op == OP_ADDI);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_halt = (op == OP_HALT);
    // SW and BEQ read their second operand through the rd field.
    assign rs1_sel = r_type ? ir[11:9] : ir[8:6];
    assign rs2_sel = (is_sw || is_beq) ? ir[11:9] : ir[8:6];
    assign rd_sel  = r_type ? ir[5:3] : ir[11:9];
    assign imm_d   = {{(DATA_W-6){ir[5]}}, ir[5:0]};
    assign imm_a   = imm_d[ADDR_W-1:0];

    always_comb begin
        alu_res = a + imm_d;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            default: alu_res = a + imm_d;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: state_next = is_halt ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (alu_op)              state_next = S_WB;
                else if (is_lw || is_sw) state_next = S_MEM;
                else                     state_next = S_FETCH;
            end
            S_MEM:    if (mem_ready) state_next = is_lw ? S_WB : S_FETCH;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir <= mem_rdata[15:0];
                    pc <= pc + PC_ONE;
                end
                S_DECODE: begin
                    a <= regs[rs1_sel];
                    b <= regs[rs2_sel];
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (is_beq && (a == b)) pc <= pc + imm_a;
                end
                S_MEM: if (mem_ready && is_lw) mdr <= mem_rdata;
                S_WB: regs[rd_sel] <= is_lw ? mdr : alu_out;
                default: ;
            endcase
        end
    end

    // Request is combinational from state so an asserted reset drops it in the same cycle.
    assign mem_req   = !reset && ((state == S_FETCH) || (state == S_MEM));
    assign mem_we    = !reset && (state == S_MEM) && is_sw;
    assign mem_addr  = (state == S_MEM) ? alu_out[ADDR_W-1:0] : pc;
    assign mem_wdata = ((state == S_MEM) && is_sw) ? b : '0;
    assign halted    = (state == S_HALT);
    assign Result    = regs[RES_IDX];

`ifdef PERF_CNT_EN
    logic [31:0] perf_cnt;
    logic        retire;

    // HALT retires on entering HALT; everything else on returning to FETCH.
    assign retire = ((state == S_EXEC || state == S_MEM || state == S_WB) && state_next == S_FETCH)
                 || (state == S_DECODE && state_next == S_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       perf_cnt <= '0;
        else if (retire) perf_cnt <= perf_cnt + 32'd1;
    end

    assign instr_count = perf_cnt;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: 16/16 core with wait-state memory model, plus a
// DATA_W=32 / ADDR_W=4 core for width and PC-wrap behaviour.
module tb_cpu_multicycle;

    logic        clk = 1'b0;
    logic        reset, rst32;
    int          total = 0;
    int          bad = 0;

    // 16-bit core and its memory model
    logic        mem_req, mem_we, mem_ready, halted;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, result;
    logic [31:0] instr_count;
    logic [15:0] mem0 [256];
    int          waits0 = 0;
    int          wcnt0 = 0;
    int          wr_cnt = 0;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    int          hold_err = 0;
    logic        prev_wait = 1'b0;
    logic [15:0] prev_addr = '0;
    logic        prev_we = 1'b0;
    logic [15:0] rd_q [$];

    // 32-bit / 4-bit-address core
    logic        mem32_req, mem32_we, mem32_ready, halted32;
    logic [3:0]  mem32_addr;
    logic [31:0] mem32_wdata, mem32_rdata, result32, instr_count32;
    logic [31:0] mem32 [16];
    logic [3:0]  rd32_q [$];

    always #5 clk = ~clk;

    cpu_multicycle dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .Result(result),
        .halted(halted), .instr_count(instr_count)
    );

    cpu_multicycle #(.DATA_W(32), .ADDR_W(4), .RESULT_REG(7)) dut32 (
        .clk(clk), .reset(rst32), .mem_req(mem32_req), .mem_we(mem32_we), .mem_addr(mem32_addr),
        .mem_wdata(mem32_wdata), .mem_rdata(mem32_rdata), .mem_ready(mem32_ready), .Result(result32),
        .halted(halted32), .instr_count(instr_count32)
    );

    assign mem_ready   = mem_req && (wcnt0 >= waits0);
    assign mem_rdata   = (wr_cnt != 0 && mem_addr[7:0] == wr_addr) ? wr_data : mem0[mem_addr[7:0]];
    assign mem32_ready = mem32_req;
    assign mem32_rdata = mem32[mem32_addr];

    always @(posedge clk) begin
        if (reset) begin
            wcnt0     <= 0;
            wr_cnt    <= 0;
            prev_wait <= 1'b0;
            rd_q.delete();
        end else begin
            wcnt0 <= (mem_req && !mem_ready) ? wcnt0 + 1 : 0;
            if (prev_wait && mem_req && (mem_addr !== prev_addr || mem_we !== prev_we))
                hold_err <= hold_err + 1;
            prev_wait <= mem_req && !mem_ready;
            prev_addr <= mem_addr;
            prev_we   <= mem_we;
            if (mem_req && mem_ready && mem_we) begin
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= mem_addr[7:0];
                wr_data <= mem_wdata;
            end
            if (mem_req && mem_ready && !mem_we) rd_q.push_back(mem_addr);
        end
    end

    always @(posedge clk) begin
        if (rst32) rd32_q.delete();
        else if (mem32_req && mem32_ready && !mem32_we) rd32_q.push_back(mem32_addr);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill0();
        for (int i = 0; i < 256; i++) mem0[i] = 16'hF000;
    endtask

    task automatic restart(input int waits);
        reset = 1'b1;
        step(2);
        waits0 = waits;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_count(input string tag, input int perf_exp);
`ifdef PERF_CNT_EN
        check(tag, instr_count, perf_exp);
`else
        check(tag, instr_count, 0);
`endif
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        rst32 = 1'b1;
        for (int i = 0; i < 16; i++) mem32[i] = 32'h0000F000;

        // ADDI R1,R0,5; ADDI R2,R0,-3; ADD R7,R1,R2; HALT
        fill0();
        mem0[0] = 16'h5205; mem0[1] = 16'h543D; mem0[2] = 16'h02B8; mem0[3] = 16'hF000;
        step(2);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_result", result, 0);
        check("rst_halted", halted, 0);
        check("rst_count", instr_count, 0);

        restart(0);
        step(11);
        check("p1_result_before_add_wb", result, 0);
        step(2);
        check("p1_result", result, 2);
        check("p1_not_halted_yet", halted, 0);
        step(1);
        check("p1_halted", halted, 1);
        check("p1_req_in_halt", mem_req, 0);
        step(5);
        check("p1_req_stays_low", mem_req, 0);
        check("p1_fetches", rd_q.size(), 4);
        check_count("p1_instr_count", 4);

        // same program, two wait cycles per request
        restart(2);
        step(19);
        check("p2_result", result, 2);
        step(2);
        check("p2_not_halted_yet", halted, 0);
        step(1);
        check("p2_halted", halted, 1);
        check("p2_hold_stable", hold_err, 0);
        check("p2_fetches", rd_q.size(), 4);

        // ADDI R1,R0,9; SW R1,[R0+20]; LW R7,[R0+20]; HALT
        fill0();
        mem0[0] = 16'h5209; mem0[1] = 16'h7214; mem0[2] = 16'h6E14;
        restart(0);
        step(15);
        check("p3_halted", halted, 1);
        check("p3_result", result, 9);
        check("p3_wr_cnt", wr_cnt, 1);
        check("p3_wr_addr", wr_addr, 20);
        check("p3_wr_data", wr_data, 9);
        check("p3_reads", rd_q.size(), 5);
        check("p3_load_addr", rd_q[3], 20);
        check_count("p3_instr_count", 4);

        // BEQ R0,R0,+2 @0; ADDI R1,R0,1 @3; BEQ R1,R0,+5 @4 (not taken); HALT @5
        fill0();
        mem0[0] = 16'h8002; mem0[3] = 16'h5201; mem0[4] = 16'h8205;
        restart(0);
        step(13);
        check("p4_halted", halted, 1);
        check("p4_fetches", rd_q.size(), 4);
        check("p4_taken_target", rd_q[1], 3);
        check("p4_after_addi", rd_q[2], 4);
        check("p4_untaken_next", rd_q[3], 5);
        check_count("p4_instr_count", 4);

        // ADDI R7,R0,9; SW R7,[R0+20]; LW R7,[R0+20]; reset while the load waits
        fill0();
        mem0[0] = 16'h5E09; mem0[1] = 16'h7E14; mem0[2] = 16'h6E14;
        restart(2);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1);
            if (mem_req && !mem_we && mem_addr == 16'd20) found = 1'b1;
        end
        check("p5_load_reached", found, 1);
        check("p5_r7_before_reset", result, 9);
        check("p5_store_done", wr_cnt, 1);
        #2 reset = 1'b1;
        #1;
        check("p5_req_dropped", mem_req, 0);
        check("p5_addr_zero", mem_addr, 0);
        check("p5_r7_cleared", result, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("p5_refetch_req", mem_req, 1);
        check("p5_refetch_addr", mem_addr, 0);
        check("p5_refetch_we", mem_we, 0);

        // 32-bit data, 4-bit PC: ADDI R7,R0,-1; ADD R7,R7,R7; BEQ ->15; BEQ @15 +1 -> 1
        mem32[0] = 32'h00005E3F; mem32[1] = 32'h00000FF8;
        mem32[2] = 32'h0000800C; mem32[15] = 32'h00008001;
        @(negedge clk);
        rst32 = 1'b0;
        step(4);
        check("w32_addi_neg1", result32, 32'hFFFFFFFF);
        step(4);
        check("w32_add_double", result32, 32'hFFFFFFFE);
        step(8);
        check("w32_fetches", rd32_q.size(), 5);
        check("w32_jump_to_15", rd32_q[3], 15);
        check("w32_pc_wrap", rd32_q[4], 1);
        check("w32_no_halt", halted32, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
